// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and sizing helpers.
package fifo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Ceiling log2; values of 0 and 1 both return 0.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    int unsigned i;
    result = 32'd0;
    for (i = 32'd0; i < 32'd32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 32'd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic int unsigned eff_level(input int unsigned level,
                                            input logic        valid,
                                            input int unsigned depth);
    if (level == 32'd0 && valid) begin
      return depth;
    end else begin
      return level;
    end
  endfunction

endpackage

// File: rtl/fifo_reader_outreg.sv
// Single-stage registered stream output: loads a beat on load, drops valid once the
// beat is taken by the consumer and nothing new replaces it.
module fifo_reader_outreg
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             tready,
  output logic             tvalid,
  output logic             tlast,
  output logic [WIDTH-1:0] tdata
);

  // Output beat register with load priority over drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tdata  <= {WIDTH{1'b0}};
    end else if (load) begin
      tvalid <= 1'b1;
      tlast  <= load_last;
      tdata  <= load_data;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tdata  <= tdata;
    end else begin
      tvalid <= tvalid;
      tlast  <= tlast;
      tdata  <= tdata;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a FIFO into AXI-Stream bursts of BURST beats; with FIFO_READER_TIMEOUT_EN
// defined, a partial burst is flushed after TIMEOUT idle cycles.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ABITS   = 4,
  parameter int BURST   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ABITS-1:0] level_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic             busy_o
);

  localparam int unsigned   DEPTH   = 32'd1 << ABITS;
  localparam int            LW      = ABITS + 1;
  localparam logic [LW-1:0] BURST_L = LW'(BURST);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [LW-1:0] ZERO_L  = {LW{1'b0}};

  if (BURST < 1 || BURST > (1 << ABITS) || TIMEOUT < 1) begin : g_bad_params
    $error("fifo_burst_reader: BURST must be 1..DEPTH and TIMEOUT >= 1");
  end

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] remaining;
  logic [LW-1:0] remaining_nxt;
  logic [LW-1:0] lvl;
  logic          load;
  logic          load_last;
  logic          last_accept;
  logic          start_full;
  logic          start_flush;

  // A full FIFO reports level 0; valid tells it apart from empty.
  assign lvl         = LW'(eff_level(32'(level_i), valid_i, DEPTH));
  assign ready_o     = (state == ST_XFER) && (remaining != ZERO_L) && (!m_tvalid || m_tready);
  assign load        = valid_i && ready_o;
  assign load_last   = (remaining == ONE_L);
  assign last_accept = m_tvalid && m_tready && m_tlast;
  assign start_full  = (lvl >= BURST_L);
  assign busy_o      = (state == ST_XFER);

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int               TBITS     = int'(clog2_f(32'(TIMEOUT + 1)));
  localparam logic [TBITS-1:0] TIMEOUT_T = TBITS'(TIMEOUT);

  logic [TBITS-1:0] timer;
  logic [TBITS-1:0] timer_nxt;

  // Idle timer: counts valid cycles while staying in IDLE, saturating at TIMEOUT.
  always_comb begin
    timer_nxt = timer;
    if (state == ST_IDLE && state_nxt == ST_IDLE && valid_i) begin
      if (timer != TIMEOUT_T) begin
        timer_nxt = timer + TBITS'(1);
      end else begin
        timer_nxt = timer;
      end
    end else begin
      timer_nxt = {TBITS{1'b0}};
    end
  end

  // Idle timer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= {TBITS{1'b0}};
    end else begin
      timer <= timer_nxt;
    end
  end

  assign start_flush = (timer == TIMEOUT_T) && (lvl != ZERO_L);
`else
  assign start_flush = 1'b0;
`endif

  // Next-state and beat-count logic; a full burst takes priority over a flush.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      ST_IDLE: begin
        if (start_full) begin
          state_nxt     = ST_XFER;
          remaining_nxt = BURST_L;
        end else if (start_flush) begin
          state_nxt     = ST_XFER;
          remaining_nxt = lvl;
        end else begin
          state_nxt     = ST_IDLE;
          remaining_nxt = remaining;
        end
      end
      ST_XFER: begin
        if (load) begin
          remaining_nxt = remaining - ONE_L;
        end else begin
          remaining_nxt = remaining;
        end
        if (last_accept) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_XFER;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        remaining_nxt = ZERO_L;
      end
    endcase
  end

  // FSM state and remaining-beat registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= ZERO_L;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  fifo_reader_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_data(data_i),
    .load_last(load_last),
    .tready   (m_tready),
    .tvalid   (m_tvalid),
    .tlast    (m_tlast),
    .tdata    (m_tdata)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a queue-based FIFO feeds the DUT and a
// word-level burst model predicts the framed output stream (FIFO_READER_TIMEOUT_EN aware).
module tb_fifo_burst_reader;

  localparam int WIDTH   = 8;
  localparam int ABITS   = 4;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 16;
  localparam int QUIET   = 100;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [ABITS-1:0] level_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] data_i = '0;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic             m_tlast;
  logic [WIDTH-1:0] m_tdata;
  logic             busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int tready_mode = 0;
  int busy_cycles = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] push_q[$];
  logic [7:0] resid[$];
  logic [7:0] exp_data[$];
  logic [7:0] got_data[$];
  bit         exp_last[$];
  bit         got_last[$];

  always #5 clock = ~clock;

  fifo_burst_reader #(
    .WIDTH(WIDTH), .ABITS(ABITS), .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .level_i (level_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast (m_tlast),
    .m_tdata (m_tdata),
    .busy_o  (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Upstream FIFO: pop on handshake, accept pending pushes, drive level/valid/data.
  initial begin : fifo_proc
    bit fire;
    bit rst_seen;
    int sz;
    forever begin
      @(posedge clock);
      fire     = valid_i && ready_o;
      rst_seen = reset;
      #1;
      if (rst_seen) begin
        fifo_q.delete();
        push_q.delete();
      end else begin
        if (fire) void'(fifo_q.pop_front());
        while (push_q.size() > 0 && fifo_q.size() < DEPTH) fifo_q.push_back(push_q.pop_front());
      end
      sz      = fifo_q.size();
      valid_i = (sz > 0);
      data_i  = (sz > 0) ? fifo_q[0] : 8'h00;
      level_i = ABITS'(sz);
      case (tready_mode)
        1:       m_tready = ~m_tready;
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Stream monitor: collects accepted beats and checks stall behaviour.
  initial begin : monitor
    bit         stall_prev;
    logic [7:0] prev_data;
    bit         prev_last;
    stall_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_eq("hold_valid", 32'(m_tvalid), 32'd1);
          check_eq("hold_data", 32'(m_tdata), 32'(prev_data));
          check_eq("hold_last", 32'(m_tlast), 32'(prev_last));
        end
        if (m_tvalid && !m_tready) check_eq("ready_drop", 32'(ready_o), 32'd0);
        if (!busy_o) check_eq("idle_ready", 32'(ready_o), 32'd0);
        if (busy_o) busy_cycles++;
        if (m_tvalid && m_tready) begin
          got_data.push_back(m_tdata);
          got_last.push_back(m_tlast);
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #3;
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    push_q.push_back(w);
    resid.push_back(w);
  endtask

  task automatic emit(input int n);
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(resid.pop_front());
      exp_last.push_back(i == n - 1);
    end
  endtask

  // Words leave in whole bursts; a leftover tail only leaves when timeout flushing exists.
  task automatic model_settle();
    while (resid.size() >= BURST) emit(BURST);
`ifdef FIFO_READER_TIMEOUT_EN
    if (resid.size() > 0) emit(resid.size());
`endif
  endtask

  task automatic wait_quiet(input string tag);
    int quiet;
    int spent;
    quiet = 0;
    spent = 0;
    while (quiet < QUIET && spent < 3000) begin
      step(1);
      spent++;
      if (!busy_o && !m_tvalid && push_q.size() == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < QUIET) check_eq({tag, "_drain"}, 32'(quiet), 32'(QUIET));
  endtask

  task automatic compare_stream(input string tag);
    int n;
    int lg;
    int le;
    model_settle();
    check_eq({tag, "_beats"}, 32'(got_data.size()), 32'(exp_data.size()));
    n  = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    lg = 0;
    le = 0;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
      check_eq({tag, "_last"}, 32'(got_last[i]), 32'(exp_last[i]));
    end
    foreach (got_last[i]) lg += int'(got_last[i]);
    foreach (exp_last[i]) le += int'(exp_last[i]);
    check_eq({tag, "_tlast_count"}, 32'(lg), 32'(le));
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  initial begin : main
    int spent;
    int n;
    step(3);
    check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_tlast", 32'(m_tlast), 32'd0);
    check_eq("rst_tdata", 32'(m_tdata), 32'd0);
    check_eq("rst_ready", 32'(ready_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    step(2);

    busy_cycles = 0;
    for (int i = 0; i < 8; i++) push_word(8'(32'h10 + i));
    wait_quiet("t1");
    check_eq("t1_busy_cycles", 32'(busy_cycles), 32'd9);
    check_eq("t1_ready_after", 32'(ready_o), 32'd0);
    compare_stream("t1");

    for (int i = 0; i < DEPTH; i++) push_word(8'(32'h40 + i));
    wait_quiet("t4");
    compare_stream("t4_full");

    tready_mode = 1;
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    wait_quiet("t5");
    tready_mode = 0;
    compare_stream("t5_stall");

    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    step(12);
    check_eq("t2_early", 32'(got_data.size()), 32'd0);
    wait_quiet("t2");
    compare_stream("t2");

    for (int i = 0; i < 20; i++) push_word(8'($urandom));
    wait_quiet("t3");
    compare_stream("t3");

    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    spent = 0;
    while (got_data.size() < 4 && spent < 500) begin
      step(1);
      spent++;
    end
    check_eq("t6_reach4", 32'(got_data.size() >= 4), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("t6_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("t6_tlast", 32'(m_tlast), 32'd0);
    check_eq("t6_busy", 32'(busy_o), 32'd0);
    check_eq("t6_ready", 32'(ready_o), 32'd0);
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
    resid.delete();
    step(2);
    for (int i = 0; i < 8; i++) push_word(8'(32'hA0 + i));
    wait_quiet("t6b");
    compare_stream("t6_after");

    tready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) push_word(8'($urandom));
      wait_quiet("rnd");
      compare_stream("rnd");
    end
    tready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
